// File: rtl/irq_ctrl.sv
// irq_ctrl: vectored interrupt controller with edge-detected pending latches, mask, global enable and fixed priority.
// Define IRQ_CTRL_NESTING_EN to allow strictly higher-priority channels to preempt a handler in service.
module irq_ctrl #(
  parameter int N_IRQ = 4,
  parameter int PCW = 10,
  parameter int VEC_BASE = 1008,
  parameter int VEC_STRIDE = 4,
  localparam int IDW = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wd,
  input  logic             gie_set,
  input  logic             gie_clr,
  input  logic             irq_ack,
  input  logic             iret,
  output logic             irq_req,
  output logic [IDW-1:0]   irq_id,
  output logic [PCW-1:0]   irq_vec,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] in_service,
  output logic             gie
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t           r_state;
  logic [N_IRQ-1:0] r_irq_q, r_pending, r_in_service, r_mask;
  logic             r_gie, r_req;
  logic [IDW-1:0]   r_id;
  logic [PCW-1:0]   r_vec;
  logic [N_IRQ-1:0] w_rise, w_prio_ok, w_elig, w_oh, w_is_next;
  logic [IDW-1:0]   w_win;
  logic             w_ack;
  assign w_rise = irq & ~r_irq_q;
  assign w_oh = N_IRQ'(1) << r_id;
  assign w_ack = (r_state == REQ) && irq_ack;
`ifdef IRQ_CTRL_NESTING_EN
  // Bits strictly below the lowest in-service bit; all ones when nothing is in service.
  assign w_prio_ok = (r_in_service & (~r_in_service + N_IRQ'(1))) - N_IRQ'(1);
  assign w_is_next = (iret ? r_in_service & (r_in_service - N_IRQ'(1)) : r_in_service) | (w_ack ? w_oh : '0);
`else
  assign w_prio_ok = '1;
  assign w_is_next = (r_in_service & ~((r_state == SERVICE && iret) ? w_oh : '0)) | (w_ack ? w_oh : '0);
`endif
  assign w_elig = r_pending & r_mask & {N_IRQ{r_gie}} & w_prio_ok;
  always_comb begin
    w_win = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (w_elig[i]) w_win = IDW'(i);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_irq_q <= '0;
      r_pending <= '0;
      r_in_service <= '0;
      r_mask <= '0;
      r_gie <= 1'b0;
    end else begin
      r_irq_q <= irq;
      r_pending <= (r_pending & ~(w_ack ? w_oh : '0)) | w_rise;
      r_in_service <= w_is_next;
      r_mask <= mask_we ? mask_wd : r_mask;
      r_gie <= gie_clr ? 1'b0 : (gie_set ? 1'b1 : r_gie);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_req <= 1'b0;
      r_id <= '0;
      r_vec <= '0;
    end else begin
      case (r_state)
        IDLE: if (|w_elig) begin
          r_id <= w_win;
          r_vec <= PCW'(VEC_BASE + int'(w_win) * VEC_STRIDE);
          r_req <= 1'b1;
          r_state <= REQ;
        end
        REQ: if (irq_ack) begin
          r_req <= 1'b0;
`ifdef IRQ_CTRL_NESTING_EN
          r_state <= IDLE;
`else
          r_state <= SERVICE;
`endif
        end else if (!w_elig[r_id]) begin
          r_req <= 1'b0;
          r_state <= IDLE;
        end
        SERVICE: if (iret) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign irq_req = r_req;
  assign irq_id = r_id;
  assign irq_vec = r_vec;
  assign pending = r_pending;
  assign in_service = r_in_service;
  assign gie = r_gie;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl (N_IRQ=4, VEC_BASE=1008, VEC_STRIDE=4).
module tb_irq_ctrl;
  logic       clk = 1'b0;
  logic       reset, mask_we, gie_set, gie_clr, irq_ack, iret;
  logic [3:0] irq, mask_wd;
  logic       irq_req, gie;
  logic [1:0] irq_id;
  logic [9:0] irq_vec;
  logic [3:0] pending, in_service;
  int         n_chk = 0, n_fail = 0;
  irq_ctrl dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_wd(mask_wd),
    .gie_set(gie_set), .gie_clr(gie_clr), .irq_ack(irq_ack), .iret(iret),
    .irq_req(irq_req), .irq_id(irq_id), .irq_vec(irq_vec), .pending(pending),
    .in_service(in_service), .gie(gie)
  );
  always #5 clk = ~clk;
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic req_is(input string tag, input logic r, input int id, input int vec);
    chk({tag, "_req"}, 32'(irq_req), 32'(r));
    if (r) begin
      chk({tag, "_id"}, 32'(irq_id), 32'(id));
      chk({tag, "_vec"}, 32'(irq_vec), 32'(vec));
    end
  endtask
  task automatic pulse(input logic [3:0] v);
    irq = v;
    step();
    irq = 4'b0;
  endtask
  task automatic do_ack();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask
  task automatic do_iret();
    iret = 1'b1;
    step();
    iret = 1'b0;
  endtask
  initial begin
    reset = 1'b0; mask_we = 1'b0; gie_set = 1'b0; gie_clr = 1'b0;
    irq_ack = 1'b0; iret = 1'b0; irq = 4'b0; mask_wd = 4'b0;
    step(2);
    req_is("rst", 1'b0, 0, 0);
    chk("rst_id", 32'(irq_id), 0);
    chk("rst_vec", 32'(irq_vec), 0);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_isv", 32'(in_service), 0);
    chk("rst_gie", 32'(gie), 0);
    reset = 1'b1; mask_we = 1'b1; mask_wd = 4'hf; gie_set = 1'b1;
    step();
    mask_we = 1'b0; gie_set = 1'b0;
    chk("gie_on", 32'(gie), 1);
`ifdef IRQ_CTRL_NESTING_EN
    pulse(4'b0100);
    step();
    req_is("n_ch2", 1'b1, 2, 1016);
    do_ack();
    chk("n_isv2", 32'(in_service), 32'h4);
    chk("n_req_drop", 32'(irq_req), 0);
    pulse(4'b0001);
    step();
    req_is("n_ch0", 1'b1, 0, 1008);
    do_ack();
    chk("n_isv02", 32'(in_service), 32'h5);
    pulse(4'b1000);
    step();
    req_is("n_ch3_blk", 1'b0, 0, 0);
    chk("n_pend3", 32'(pending), 32'h8);
    do_iret();
    chk("n_iret1", 32'(in_service), 32'h4);
    step();
    req_is("n_ch3_blk2", 1'b0, 0, 0);
    do_iret();
    chk("n_iret2", 32'(in_service), 32'h0);
    step();
    req_is("n_ch3", 1'b1, 3, 1020);
`else
    pulse(4'b0100);
    chk("t1_pend", 32'(pending), 32'h4);
    chk("t1_req_early", 32'(irq_req), 0);
    step();
    req_is("t1", 1'b1, 2, 1016);
    do_ack();
    chk("t1_isv", 32'(in_service), 32'h4);
    chk("t1_pend_clr", 32'(pending), 0);
    do_iret();
    chk("t1_iret", 32'(in_service), 0);
    pulse(4'b1010);
    chk("t2_pend", 32'(pending), 32'ha);
    step();
    req_is("t2_ch1", 1'b1, 1, 1012);
    do_ack();
    chk("t2_pend_ack", 32'(pending), 32'h8);
    chk("t2_isv", 32'(in_service), 32'h2);
    chk("t2_req_drop", 32'(irq_req), 0);
    step();
    chk("t2_svc_hold", 32'(irq_req), 0);
    do_iret();
    chk("t2_iret", 32'(in_service), 0);
    step();
    req_is("t2_ch3", 1'b1, 3, 1020);
    do_ack();
    do_iret();
    pulse(4'b0001);
    step();
    req_is("t3_ch0", 1'b1, 0, 1008);
    mask_we = 1'b1; mask_wd = 4'b1110;
    step();
    mask_we = 1'b0;
    step();
    chk("t3_withdraw", 32'(irq_req), 0);
    chk("t3_pend_kept", 32'(pending), 32'h1);
    do_ack();
    chk("t3_ack_idle_pend", 32'(pending), 32'h1);
    chk("t3_ack_idle_isv", 32'(in_service), 0);
    mask_we = 1'b1; mask_wd = 4'hf;
    step();
    mask_we = 1'b0;
    step();
    req_is("t3_reissue", 1'b1, 0, 1008);
    do_ack();
    do_iret();
    pulse(4'b0100);
    step();
    req_is("t4_ch2", 1'b1, 2, 1016);
    irq = 4'b0100; irq_ack = 1'b1;
    step();
    irq = 4'b0; irq_ack = 1'b0;
    chk("t4_isv", 32'(in_service), 32'h4);
    chk("t4_pend_set_wins", 32'(pending), 32'h4);
    do_iret();
    step();
    req_is("t4_reissue", 1'b1, 2, 1016);
    reset = 1'b0;
    step();
    reset = 1'b1;
    req_is("t5_rst", 1'b0, 0, 0);
    chk("t5_id", 32'(irq_id), 0);
    chk("t5_vec", 32'(irq_vec), 0);
    chk("t5_pend", 32'(pending), 0);
    chk("t5_gie", 32'(gie), 0);
    gie_set = 1'b1; gie_clr = 1'b1;
    step();
    gie_set = 1'b0; gie_clr = 1'b0;
    chk("t5_gie_clr_wins", 32'(gie), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
